prio_decoder_buf: RTL and testbench
===================================

Name: prio_decoder_buf

Overview:
- Registered, buffered N-to-2^N decoder: the inverse of the team's 8:3 priority encoder.
- Accepts a binary code plus "any" flag on a valid/ready input channel.
- Stores the decoded one-hot word in a small FIFO and presents it on a valid/ready output channel.
- Sits downstream of the priority encoder to regenerate grant/select lines with flow control.

Parameters:
- CODE_W, 3, width of input code; output width is 2**CODE_W (default 8).
- DEPTH, 2, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input word present.
- in_code  input  CODE_W  binary index to decode.
- in_any  input  1  1 = code meaningful; 0 = encoder saw no bit set, decode to all zeros.
- in_ready  output  1  block can accept a word this cycle.
- out_valid  output  1  head entry available.
- out_onehot  output  2**CODE_W  decoded word at FIFO head.
- out_ready  input  1  consumer takes head this cycle.

Behaviour:
- Reset: synchronous, active-high; sampled on clk rising edge.
  - Reset values: count=0, rd_ptr=0, wr_ptr=0, out_valid=0, out_onehot=0, in_ready=0 while rst high.
  - Storage contents need not be cleared.
- Decode rule:
  - in_any=1: entry = 1 << in_code.
  - in_any=0: entry = 0, regardless of in_code.
  - Decoding happens before storage; the FIFO holds one-hot words.
- Push/pop conditions:
  - push = in_valid && in_ready; pop = out_valid && out_ready.
  - in_ready = !rst && (count != DEPTH).
  - in_ready is derived from registered count only; no combinational path from out_ready.
  - out_valid = (count != 0).
  - out_onehot = mem[rd_ptr] when out_valid, else all zeros.
- Latency: word accepted in cycle N into an empty FIFO gives out_valid=1 with that word in cycle N+1.
- Simultaneous push and pop, 0 < count < DEPTH: both pointers advance; count unchanged.
- Full (count=DEPTH):
  - in_ready=0; push is blocked even if pop happens the same cycle.
  - in_ready rises the cycle after a pop.
- Empty:
  - pop cannot occur (out_valid=0).
  - A push in the same cycle is not bypassed; it appears next cycle.
- Pointers: wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- Out-of-range: in_code values are always in range, since 2**CODE_W covers all codes.
- Stall: while out_valid=1 and out_ready=0, out_onehot holds stable.
- Reset mid-operation: all pending entries are discarded; out_valid=0 in the cycle after rst is sampled high.
- State machine: implicit in count, with three states:
  - EMPTY (count=0)
  - PARTIAL (0<count<DEPTH)
  - FULL (count=DEPTH)
  - Transitions are driven only by push/pop as above.

Optional Feature:
- Macro: PRIO_DECODER_BUF_STATS_EN.
- Defined:
  - Adds output port word_cnt, 16 bits.
  - Increments on every pop; wraps 0xFFFF -> 0x0000.
  - Cleared by rst.
  - Adds output port zero_cnt, 16 bits: counts pops whose word is all zeros, same wrap and reset rules.
- Undefined: neither port exists; no counter logic is synthesised. Core behaviour is identical either way.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0, out_onehot=8'h00, in_ready=0; after rst=0 -> in_ready=1.
- Single decode: push in_code=3'd7, in_any=1, out_ready=1 -> next cycle out_valid=1, out_onehot=8'b10000000; cycle after, out_valid=0.
- Sweep: push codes 0..7 with out_ready=1 -> out_onehot sequence 8'h01,02,04,08,10,20,40,80, each one cycle after its push.
- No-bit input: push in_any=0, in_code=3'd5 -> out_onehot=8'h00 with out_valid=1.
- Backpressure/full: out_ready=0, push codes 1 and 2 -> in_ready=0 after second push; third push (code 4) is ignored; then out_ready=1 -> outputs 8'h02, then 8'h04 (codes 1 and 2); code 4 is never output.
- Reset mid-operation: FIFO full (codes 6, 0), assert rst one cycle -> out_valid=0 next cycle; with the stats macro defined, word_cnt=0.

Source files
------------

// File: rtl/prio_decoder_buf.sv
// Buffered N-to-2^N decoder: decodes {in_any, in_code} to a one-hot word and queues it in a DEPTH-entry FIFO.
// Optional per-pop statistics (word_cnt, zero_cnt) are enabled by defining PRIO_DECODER_BUF_STATS_EN.
module prio_decoder_buf #(
  parameter int CODE_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [CODE_W-1:0]        in_code,
  input  logic                     in_any,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [(2**CODE_W)-1:0]   out_onehot,
  input  logic                     out_ready
`ifdef PRIO_DECODER_BUF_STATS_EN
  ,
  output logic [15:0]              word_cnt,
  output logic [15:0]              zero_cnt
`endif
);

  localparam int OUT_W = 2 ** CODE_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Occupancy class; kept as a register alongside count so the handshake outputs are plain flop decodes.
  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [OUT_W-1:0]   mem [DEPTH];
  logic [OUT_W-1:0]   decoded;
  logic [OUT_W-1:0]   head;
  logic               push;
  logic               pop;

  assign in_ready   = !rst && (state != FULL);
  assign out_valid  = (state != EMPTY);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign head       = mem[rd_ptr];
  assign out_onehot = out_valid ? head : '0;

  always_comb begin
    decoded = '0;
    if (in_any) begin
      decoded[in_code] = 1'b1;
    end
  end

  always_comb begin
    count_next = count;
    state_next = state;
    unique case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
    if (count_next == '0) begin
      state_next = EMPTY;
    end else if (count_next == FULL_CNT) begin
      state_next = FULL;
    end else begin
      state_next = PARTIAL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage is never cleared; reset only invalidates it through count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= decoded;
    end
  end

`ifdef PRIO_DECODER_BUF_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
      zero_cnt <= '0;
    end else if (pop) begin
      word_cnt <= word_cnt + 16'd1;
      if (head == '0) begin
        zero_cnt <= zero_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_prio_decoder_buf.sv
// Scoreboard bench for prio_decoder_buf: accepted pushes queue their hand-computed word, a monitor checks the head.
// Stats ports are connected and checked when PRIO_DECODER_BUF_STATS_EN is defined.
module tb_prio_decoder_buf;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_any;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_onehot;
  logic       out_ready;
`ifdef PRIO_DECODER_BUF_STATS_EN
  logic [15:0] word_cnt;
  logic [15:0] zero_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int pops_seen = 0;
  int zeros_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sweep_tbl[8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic acc;

  prio_decoder_buf #(.CODE_W(3), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_code    (in_code),
    .in_any     (in_any),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_onehot (out_onehot),
    .out_ready  (out_ready)
`ifdef PRIO_DECODER_BUF_STATS_EN
    ,
    .word_cnt   (word_cnt),
    .zero_cnt   (zero_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: whenever a word is presented it must equal the scoreboard head; a handshake retires it.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word: got %0h expected none", out_onehot);
      end else begin
        checkOutput("head_word", 32'(out_onehot), 32'(exp_q[0]));
        if (out_ready) begin
          pops_seen++;
          if (exp_q[0] == 8'h00) zeros_seen++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Called at posedge+1; returns aligned at the next posedge+1.
  task automatic applyStimulus(input logic [2:0] code, input logic any, input logic [7:0] exp_word,
                               input logic rdy, output logic accepted);
    in_valid  = 1'b1;
    in_code   = code;
    in_any    = any;
    out_ready = rdy;
    @(negedge clk);
    accepted = in_ready;
    if (accepted) exp_q.push_back(exp_word);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drainQueue(input string name);
    logic done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    checkOutput(name, 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_code   = 3'd0;
    in_any    = 1'b0;
    out_ready = 1'b0;

    // Reset held for two cycles
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_onehot", 32'(out_onehot), 32'h00);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
    checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Single decode with one-cycle latency
    applyStimulus(3'd7, 1'b1, 8'h80, 1'b1, acc);
    checkOutput("single_accept", 32'(acc), 32'd1);
    @(negedge clk);
    checkOutput("single_valid", 32'(out_valid), 32'd1);
    checkOutput("single_word", 32'(out_onehot), 32'h80);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("single_gone", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back sweep of all codes
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'(i), 1'b1, sweep_tbl[i], 1'b1, acc);
      checkOutput("sweep_accept", 32'(acc), 32'd1);
    end
    drainQueue("sweep_drain");

    // in_any=0 decodes to zero regardless of code
    applyStimulus(3'd5, 1'b0, 8'h00, 1'b1, acc);
    @(negedge clk);
    checkOutput("nobit_valid", 32'(out_valid), 32'd1);
    checkOutput("nobit_word", 32'(out_onehot), 32'h00);
    @(posedge clk);
    #1;
    drainQueue("nobit_drain");

    // Backpressure until full; third push must be refused
    applyStimulus(3'd1, 1'b1, 8'h02, 1'b0, acc);
    checkOutput("bp_accept1", 32'(acc), 32'd1);
    applyStimulus(3'd2, 1'b1, 8'h04, 1'b0, acc);
    checkOutput("bp_accept2", 32'(acc), 32'd1);
    @(negedge clk);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(3'd4, 1'b1, 8'h10, 1'b0, acc);
    checkOutput("full_blocked", 32'(acc), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("full_ready_before_pop", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("ready_after_pop", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    drainQueue("bp_drain");

`ifdef PRIO_DECODER_BUF_STATS_EN
    checkOutput("stats_words", 32'(word_cnt), 32'd12);
    checkOutput("stats_zeros", 32'(zero_cnt), 32'd1);
    checkOutput("stats_words_model", 32'(word_cnt), 32'(pops_seen));
`endif

    // Reset while full discards both entries
    applyStimulus(3'd6, 1'b1, 8'h40, 1'b0, acc);
    applyStimulus(3'd0, 1'b1, 8'h01, 1'b0, acc);
    @(negedge clk);
    checkOutput("pre_rst_full", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    pops_seen  = 0;
    zeros_seen = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_word", 32'(out_onehot), 32'h00);
    checkOutput("midrst_ready", 32'(in_ready), 32'd1);
`ifdef PRIO_DECODER_BUF_STATS_EN
    checkOutput("midrst_word_cnt", 32'(word_cnt), 32'd0);
    checkOutput("midrst_zero_cnt", 32'(zero_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;

    // Recovery after reset
    applyStimulus(3'd3, 1'b1, 8'h08, 1'b1, acc);
    checkOutput("recover_accept", 32'(acc), 32'd1);
    drainQueue("recover_drain");
`ifdef PRIO_DECODER_BUF_STATS_EN
    checkOutput("final_word_cnt", 32'(word_cnt), 32'd1);
    checkOutput("final_zero_cnt", 32'(zero_cnt), 32'(zeros_seen));
`endif
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
